// File: rtl/cache_arbiter_pkg.sv
// Shared types and helpers for the I/D-cache to physical-memory arbiter.
package cache_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } cache_arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } cache_arb_grant_t;

  // Saturating increment used by the starvation counter.
  function automatic logic [3:0] starve_sat_inc(input logic [3:0] cnt, input logic [3:0] limit);
    logic [3:0] res;
    if (cnt >= limit) begin
      res = limit;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_arbiter_checker.sv
// Simulation-only protocol checks for cache_arbiter, instantiated alongside the design.
module cache_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic d_pmem_read,
  input logic d_pmem_write,
  input logic i_pmem_resp,
  input logic d_pmem_resp
);

  // A D-cache read and writeback in the same cycle is illegal (the arbiter treats it as a write).
  a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write))
    else $error("cache_arbiter_checker: d_pmem_read and d_pmem_write both asserted");

  // Only one cache can ever be completed in a given cycle.
  a_resp_onehot : assert property (@(posedge clk) disable iff (rst) !(i_pmem_resp && d_pmem_resp))
    else $error("cache_arbiter_checker: i_pmem_resp and d_pmem_resp both asserted");

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single pmem line port between I-cache and D-cache misses, one transaction at a time,
// D-cache first with a bounded starvation count guaranteeing I-cache progress.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  cache_arb_state_t state_r, state_next_s;
  cache_arb_grant_t grant_r, grant_next_s;
  logic [3:0]        starve_cnt_r;
  logic [31:0]       addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              write_r;
  logic              take_s;
  logic              i_req_s;
  logic              d_req_s;
  logic              starve_hit_s;

  assign i_req_s      = i_pmem_read;
  assign d_req_s      = d_pmem_read | d_pmem_write;
  assign starve_hit_s = (starve_cnt_r == STARVE_MAX);

  // Grant selection in IDLE and next-state logic.
  always_comb begin
    state_next_s = state_r;
    grant_next_s = grant_r;
    take_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          take_s       = 1'b1;
          grant_next_s = starve_hit_s ? GRANT_I : GRANT_D;
        end else if (i_req_s) begin
          take_s       = 1'b1;
          grant_next_s = GRANT_I;
        end else if (d_req_s) begin
          take_s       = 1'b1;
          grant_next_s = GRANT_D;
        end else begin
          take_s       = 1'b0;
        end
        if (take_s) begin
          state_next_s = (grant_next_s == GRANT_I) ? SERVE_I : SERVE_D;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, grant, starvation counter and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= GRANT_I;
      starve_cnt_r <= 4'd0;
      addr_r       <= 32'd0;
      wdata_r      <= {LINE_W{1'b0}};
      write_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      grant_r <= grant_next_s;
      if (take_s) begin
        if (grant_next_s == GRANT_I) begin
          addr_r       <= i_pmem_address;
          wdata_r      <= {LINE_W{1'b0}};
          write_r      <= 1'b0;
          starve_cnt_r <= 4'd0;
        end else begin
          addr_r  <= d_pmem_address;
          wdata_r <= d_pmem_wdata;
          // Simultaneous read+write from D resolves to a writeback.
          write_r <= d_pmem_write;
          if (i_req_s) begin
            starve_cnt_r <= starve_sat_inc(starve_cnt_r, STARVE_MAX);
          end else begin
            starve_cnt_r <= starve_cnt_r;
          end
        end
      end
    end
  end

  // Output decode keyed on state; resp is a pass-through of pmem_resp for the served side only.
  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state_r)
      SERVE_I, SERVE_D: begin
        pmem_read  = ~write_r;
        pmem_write = write_r;
        if (grant_r == GRANT_I) begin
          i_pmem_resp = pmem_resp;
        end else begin
          d_pmem_resp = pmem_resp;
        end
      end
      IDLE, DONE: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
  assign arb_busy     = (state_r != IDLE);

endmodule
